// File: rtl/alu_serial.sv
// Digit-serial ALU: latches operands on start, then processes DIGIT bits per cycle LSB first.
// The result, zero and illegal outputs update when the operation finishes, alongside a one-cycle done pulse.
module alu_serial #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       alucont,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    // S_ILL spends the one non-busy cycle an illegal op takes before reporting
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_ILL, S_FIN} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [2:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             zero_q, zero_d, illegal_q, illegal_d;

    logic [DIGIT-1:0] a_s, b_s, bx, slice;
    logic [DIGIT:0]   sum_w;
    logic             op_inv, less, in_legal, in_inv;
    logic [WIDTH-1:0] acc_next;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        result_d  = result_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;

        // Current digit slice: subtract is A + ~B with carry-in of 1 on the first slice
        a_s    = a_q[DIGIT-1:0];
        b_s    = b_q[DIGIT-1:0];
        op_inv = (op_q == OP_SUB) || (op_q == OP_SLT);
        bx     = op_inv ? ~b_s : b_s;
        sum_w  = {1'b0, a_s} + {1'b0, bx} + {{DIGIT{1'b0}}, carry_q};
        case (op_q)
            OP_AND:  slice = a_s & b_s;
            OP_OR:   slice = a_s | b_s;
            default: slice = sum_w[DIGIT-1:0];
        endcase
        // less = diff_msb ^ overflow, where overflow = carry into msb ^ carry out
        less     = sum_w[DIGIT] ^ a_s[DIGIT-1] ^ bx[DIGIT-1];
        acc_next = (acc_q >> DIGIT) | (WIDTH'(slice) << (WIDTH - DIGIT));

        in_legal = (alucont == OP_AND) || (alucont == OP_OR) || (alucont == OP_ADD) ||
                   (alucont == OP_SUB) || (alucont == OP_SLT);
        in_inv   = (alucont == OP_SUB) || (alucont == OP_SLT);

        case (state_q)
            S_IDLE, S_FIN: begin
                state_d = S_IDLE;
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = alucont;
                    acc_d   = '0;
                    cnt_d   = '0;
                    carry_d = in_inv;
                    state_d = in_legal ? S_RUN : S_ILL;
                end
            end
            S_RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                acc_d   = acc_next;
                carry_d = sum_w[DIGIT];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d   = S_FIN;
                    result_d  = (op_q == OP_SLT) ? WIDTH'(less) : acc_next;
                    zero_d    = (result_d == '0);
                    illegal_d = 1'b0;
                end
            end
            S_ILL: begin
                state_d   = S_FIN;
                result_d  = '0;
                zero_d    = 1'b1;
                illegal_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_FIN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            result_q  <= '0;
            op_q      <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign result  = result_q;
    assign zero    = zero_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_serial.sv
// Bench for alu_serial: directed cases with literal expectations, then random traffic checked
// every cycle against a transaction-level model.
module tb_alu_serial;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DIGIT = 4;
    localparam int          N     = 8;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic             clk = 1'b0;
    logic             reset, start, busy, done, zero, illegal;
    logic [2:0]       alucont;
    logic [WIDTH-1:0] a, b, result;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    alu_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk(clk), .reset(reset), .start(start), .alucont(alucont), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .zero(zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic bit legal_op(input logic [2:0] op);
        return op inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT};
    endfunction

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        case (op)
            OP_ADD:  return x + y;
            OP_SUB:  return x - y;
            OP_AND:  return x & y;
            OP_OR:   return x | y;
            OP_SLT:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Transaction model: an accepted op reports N edges later (legal) or 1 edge later (illegal)
    int          rem = 0;
    bit          m_legal = 1'b0;
    logic [31:0] m_pend = '0;
    logic        m_busy = 1'b0, m_done = 1'b0, m_zero = 1'b1, m_ill = 1'b0;
    logic [31:0] m_res = '0;

    always @(posedge clk) begin
        if (reset) begin
            rem = 0; m_busy = 0; m_done = 0; m_res = '0; m_zero = 1; m_ill = 0;
        end else begin
            m_done = 0;
            if (rem > 0) begin
                rem--;
                if (rem == 0) begin
                    m_done = 1; m_res = m_pend; m_zero = (m_pend == 0); m_ill = !m_legal;
                end
            end else if (start) begin
                m_legal = legal_op(alucont);
                m_pend  = m_legal ? ref_alu(alucont, a, b) : 32'd0;
                rem     = m_legal ? N : 1;
            end
            m_busy = (rem > 0) && m_legal;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("result", result, m_res);
            chk("zero", 32'(zero), 32'(m_zero));
            chk("illegal", 32'(illegal), 32'(m_ill));
        end
    end

    // Called at a negedge; returns at the negedge on which done is seen
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp_res, input bit exp_ill, input int exp_lat,
                          input bit junk, output int busy_cnt);
        int cyc;
        bit got;
        alucont = op; a = x; b = y; start = 1'b1;
        cyc = 0; got = 0; busy_cnt = 0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            busy_cnt += int'(busy);
            if (done) got = 1;
            else begin
                start = junk && (cyc == 2 || cyc == 4);
                if (start) begin
                    alucont = 3'($urandom); a = $urandom; b = $urandom;
                end
            end
        end
        start = 1'b0;
        chk({name, "_done_seen"}, 32'(got), 32'd1);
        chk({name, "_latency"}, 32'(cyc), 32'(exp_lat));
        chk({name, "_result"}, result, exp_res);
        chk({name, "_zero"}, 32'(zero), (exp_res == 0) ? 32'd1 : 32'd0);
        chk({name, "_illegal"}, 32'(illegal), 32'(exp_ill));
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int bc;
        bit saw;
        logic [2:0] ops [5];
        ops[0] = OP_AND; ops[1] = OP_OR; ops[2] = OP_ADD; ops[3] = OP_SUB; ops[4] = OP_SLT;

        reset = 1'b1; start = 1'b0; alucont = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", 32'(zero), 32'd1);
        chk("rst_illegal", 32'(illegal), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, 9, 0, bc);
        chk("add_busy_cycles", 32'(bc), 32'd8);
        @(negedge clk);
        run_op("sub_eq", OP_SUB, 32'd5, 32'd5, 32'd0, 0, 9, 0, bc);
        @(negedge clk);
        run_op("sub_neg", OP_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 0, 9, 0, bc);
        @(negedge clk);
        run_op("slt_neg", OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 9, 0, bc);
        @(negedge clk);
        run_op("slt_ovf", OP_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 0, 9, 0, bc);
        @(negedge clk);
        run_op("and_junk", OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, 9, 1, bc);
        @(negedge clk);
        run_op("or_junk", OP_OR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 0, 9, 1, bc);
        @(negedge clk);
        run_op("illegal", 3'b101, 32'h1234, 32'h5678, 32'd0, 1, 2, 0, bc);
        chk("illegal_busy_cycles", 32'(bc), 32'd0);
        run_op("b2b_add", OP_ADD, 32'd2, 32'd3, 32'd5, 0, 9, 0, bc);
        @(negedge clk);

        // Reset during RUN cycle 4 of an add
        alucont = OP_ADD; a = 32'd1; b = 32'd2; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_zero", 32'(zero), 32'd1);
        saw = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) saw = 1;
        end
        chk("abort_no_done", 32'(saw), 32'd0);

        // Random traffic: starts at any time, occasional illegal ops and resets
        repeat (3000) begin
            @(negedge clk);
            reset   = ($urandom_range(0, 199) == 0);
            start   = ($urandom_range(0, 2) == 0);
            alucont = ($urandom_range(0, 4) == 0) ? 3'($urandom) : ops[$urandom_range(0, 4)];
            a       = pick_val();
            b       = pick_val();
        end
        reset = 1'b0; start = 1'b0;
        repeat (12) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
